// File: rtl/health_shield_tracker_pkg.sv
// Shared definitions for the health/shield tracker: level widths, round FSM
// encoding, default tuning values and the saturating level arithmetic.
package health_shield_tracker_pkg;

  localparam int LVL_W = 4;
  localparam int CNT_W = 6;

  localparam int DEF_MAX_HEALTH   = 15;
  localparam int DEF_MAX_SHIELD   = 15;
  localparam int DEF_HIT_DAMAGE   = 2;
  localparam int DEF_SHIELD_COST  = 3;
  localparam int DEF_IFRAME_TICKS = 30;
  localparam int DEF_REGEN_TICKS  = 60;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FIGHT = 2'd1;
  localparam logic [1:0] ST_KO    = 2'd2;

  typedef struct packed {
    logic [LVL_W-1:0] health;
    logic [LVL_W-1:0] shield;
  } vitals_t;

  // One extra bit catches the borrow so a level clamps at 0 instead of wrapping.
  function automatic logic [LVL_W-1:0] sat_sub(input logic [LVL_W-1:0] a,
                                               input logic [LVL_W-1:0] b);
    logic [LVL_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[LVL_W] ? '0 : d[LVL_W-1:0];
  endfunction

endpackage

// File: rtl/health_shield_tracker_player_vitals.sv
// Per-player health/shield state: hit and block resolution, invincibility
// frames and frame-timed shield regeneration.
module player_vitals
  import health_shield_tracker_pkg::*;
#(
  parameter int MAX_HEALTH   = DEF_MAX_HEALTH,
  parameter int MAX_SHIELD   = DEF_MAX_SHIELD,
  parameter int HIT_DAMAGE   = DEF_HIT_DAMAGE,
  parameter int SHIELD_COST  = DEF_SHIELD_COST,
  parameter int IFRAME_TICKS = DEF_IFRAME_TICKS,
  parameter int REGEN_TICKS  = DEF_REGEN_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             active,
  input  logic             frame_tick,
  input  logic             hit,
  input  logic             blocking,
  output logic [LVL_W-1:0] health,
  output logic [LVL_W-1:0] shield,
  output logic             zero_health
);

  logic [LVL_W-1:0] health_q, health_d, shield_q, shield_d;
  logic [CNT_W-1:0] iframe_q, iframe_d, regen_q, regen_d;
  logic             accept;

  always_comb begin
    health_d = health_q;
    shield_d = shield_q;
    iframe_d = iframe_q;
    regen_d  = regen_q;
    accept   = hit && (iframe_q == '0);
    if (load) begin
      health_d = LVL_W'(MAX_HEALTH);
      shield_d = LVL_W'(MAX_SHIELD);
      iframe_d = '0;
      regen_d  = '0;
    end else if (active) begin
      if (accept) begin
        // An accepted hit swallows a coincident tick: iframe reloads, regen restarts.
        iframe_d = CNT_W'(IFRAME_TICKS);
        regen_d  = '0;
        if (blocking && (shield_q >= LVL_W'(SHIELD_COST))) begin
          shield_d = shield_q - LVL_W'(SHIELD_COST);
        end else begin
          if (blocking) shield_d = '0;
          health_d = sat_sub(health_q, LVL_W'(HIT_DAMAGE));
        end
      end else if (frame_tick) begin
        if (iframe_q != '0) iframe_d = iframe_q - CNT_W'(1);
        if (blocking || (shield_q == LVL_W'(MAX_SHIELD))) begin
          regen_d = '0;
        end else if (regen_q == CNT_W'(REGEN_TICKS - 1)) begin
          shield_d = shield_q + LVL_W'(1);
          regen_d  = '0;
        end else begin
          regen_d = regen_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      health_q <= LVL_W'(MAX_HEALTH);
      shield_q <= LVL_W'(MAX_SHIELD);
      iframe_q <= '0;
      regen_q  <= '0;
    end else begin
      health_q <= health_d;
      shield_q <= shield_d;
      iframe_q <= iframe_d;
      regen_q  <= regen_d;
    end
  end

  assign health = health_q;
  assign shield = shield_q;
  // Looks at the next value so KO can be registered on the same edge as health.
  assign zero_health = (health_d == '0);

endmodule

// File: rtl/health_shield_tracker.sv
// Round sequencing for two players: IDLE -> FIGHT -> KO, with round_start
// reloading both players' vitals from any state.
module health_shield_tracker
  import health_shield_tracker_pkg::*;
#(
  parameter int MAX_HEALTH   = DEF_MAX_HEALTH,
  parameter int MAX_SHIELD   = DEF_MAX_SHIELD,
  parameter int HIT_DAMAGE   = DEF_HIT_DAMAGE,
  parameter int SHIELD_COST  = DEF_SHIELD_COST,
  parameter int IFRAME_TICKS = DEF_IFRAME_TICKS,
  parameter int REGEN_TICKS  = DEF_REGEN_TICKS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       round_start,
  input  logic       p1_hit,
  input  logic       p1_blocking,
  input  logic       p2_hit,
  input  logic       p2_blocking,
  output logic [3:0] p1_health,
  output logic [3:0] p1_shield,
  output logic [3:0] p2_health,
  output logic [3:0] p2_shield,
  output logic [1:0] ko,
  output logic       fighting
);

  localparam int NUM_PLAYERS = 2;

  logic [1:0]                   state_q, state_d;
  logic [NUM_PLAYERS-1:0]       ko_q, ko_d;
  logic [NUM_PLAYERS-1:0]       hit, blocking, zero;
  vitals_t [NUM_PLAYERS-1:0]    vit;
  logic                         active;

  assign hit      = {p2_hit, p1_hit};
  assign blocking = {p2_blocking, p1_blocking};
  assign active   = (state_q == ST_FIGHT) && !round_start;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    player_vitals #(
      .MAX_HEALTH  (MAX_HEALTH),
      .MAX_SHIELD  (MAX_SHIELD),
      .HIT_DAMAGE  (HIT_DAMAGE),
      .SHIELD_COST (SHIELD_COST),
      .IFRAME_TICKS(IFRAME_TICKS),
      .REGEN_TICKS (REGEN_TICKS)
    ) u_vitals (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (round_start),
      .active     (active),
      .frame_tick (frame_tick),
      .hit        (hit[g]),
      .blocking   (blocking[g]),
      .health     (vit[g].health),
      .shield     (vit[g].shield),
      .zero_health(zero[g])
    );
  end

  always_comb begin
    state_d = state_q;
    ko_d    = ko_q;
    if (round_start) begin
      state_d = ST_FIGHT;
      ko_d    = '0;
    end else if ((state_q == ST_FIGHT) && (|zero)) begin
      state_d = ST_KO;
      ko_d    = zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ko_q    <= '0;
    end else begin
      state_q <= state_d;
      ko_q    <= ko_d;
    end
  end

  assign p1_health = vit[0].health;
  assign p1_shield = vit[0].shield;
  assign p2_health = vit[1].health;
  assign p2_shield = vit[1].shield;
  assign ko        = ko_q;
  assign fighting  = (state_q == ST_FIGHT);

endmodule

// File: tb/tb_health_shield_tracker.sv
// Bench for health_shield_tracker: game-rule model checked every cycle plus
// directed scenarios with literal expectations.
module tb_health_shield_tracker;

  localparam int MAXH = 15, MAXS = 15, DMG = 2, COST = 3, IFR = 30, REGEN = 60;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, round_start, p1_hit, p1_blocking, p2_hit, p2_blocking;
  logic [3:0] p1_health, p1_shield, p2_health, p2_shield;
  logic [1:0] ko;
  logic       fighting;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  health_shield_tracker #(
    .MAX_HEALTH(MAXH), .MAX_SHIELD(MAXS), .HIT_DAMAGE(DMG),
    .SHIELD_COST(COST), .IFRAME_TICKS(IFR), .REGEN_TICKS(REGEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .round_start(round_start),
    .p1_hit(p1_hit), .p1_blocking(p1_blocking), .p2_hit(p2_hit), .p2_blocking(p2_blocking),
    .p1_health(p1_health), .p1_shield(p1_shield), .p2_health(p2_health),
    .p2_shield(p2_shield), .ko(ko), .fighting(fighting)
  );

  // ---------------- game-rule model ----------------
  typedef struct {
    int h;
    int s;
    int i;
    int r;
  } pm_t;

  pm_t m[2];
  bit  m_fight;
  int  m_ko;

  function automatic pm_t full();
    pm_t f;
    f.h = MAXH; f.s = MAXS; f.i = 0; f.r = 0;
    return f;
  endfunction

  function automatic pm_t pstep(pm_t c, bit hit, bit blk, bit tk);
    pm_t n = c;
    if (hit && c.i == 0) begin
      if (blk && c.s >= COST) n.s = c.s - COST;
      else begin
        if (blk) n.s = 0;
        n.h = (c.h > DMG) ? c.h - DMG : 0;
      end
      n.i = IFR;
      n.r = 0;
    end else if (tk) begin
      if (c.i > 0) n.i = c.i - 1;
      if (blk || c.s == MAXS) n.r = 0;
      else if (c.r + 1 == REGEN) begin
        n.s = c.s + 1;
        n.r = 0;
      end else n.r = c.r + 1;
    end
    return n;
  endfunction

  function automatic int knock(pm_t a, pm_t b);
    return ((b.h == 0) ? 2 : 0) + ((a.h == 0) ? 1 : 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= full(); m[1] <= full(); m_fight <= 1'b0; m_ko <= 0;
    end else if (round_start) begin
      m[0] <= full(); m[1] <= full(); m_fight <= 1'b1; m_ko <= 0;
    end else if (m_fight) begin
      m[0] <= pstep(m[0], p1_hit, p1_blocking, frame_tick);
      m[1] <= pstep(m[1], p2_hit, p2_blocking, frame_tick);
      if (knock(pstep(m[0], p1_hit, p1_blocking, frame_tick),
                pstep(m[1], p2_hit, p2_blocking, frame_tick)) != 0) begin
        m_fight <= 1'b0;
        m_ko    <= knock(pstep(m[0], p1_hit, p1_blocking, frame_tick),
                         pstep(m[1], p2_hit, p2_blocking, frame_tick));
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_p1_health", p1_health, m[0].h);
    chk("model_p1_shield", p1_shield, m[0].s);
    chk("model_p2_health", p2_health, m[1].h);
    chk("model_p2_shield", p2_shield, m[1].s);
    chk("model_ko", ko, m_ko);
    chk("model_fighting", fighting, m_fight);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic rs, input logic ft, input logic h1, input logic h2);
    @(negedge clk);
    round_start = rs; frame_tick = ft; p1_hit = h1; p2_hit = h2;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    round_start = 0; frame_tick = 0; p1_hit = 0; p2_hit = 0;
    p1_blocking = 0; p2_blocking = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p1_health", p1_health, 15);
    chk("rst_p2_shield", p2_shield, 15);
    chk("rst_fighting", fighting, 0);
    chk("rst_ko", ko, 0);
    @(negedge clk) rst_n = 1'b1;

    cyc(0, 1, 1, 1);
    chk("idle_hit_ignored", p1_health, 15);
    chk("idle_not_fighting", fighting, 0);

    cyc(1, 0, 0, 0);
    chk("start_fighting", fighting, 1);
    chk("start_p1_health", p1_health, 15);
    chk("start_p2_shield", p2_shield, 15);
    chk("start_ko", ko, 0);

    // invincibility frames on P1
    cyc(0, 0, 1, 0); chk("p1_first_hit", p1_health, 13);
    ticks(5);  cyc(0, 0, 1, 0); chk("p1_drop_5ticks", p1_health, 13);
    ticks(24); cyc(0, 0, 1, 0); chk("p1_drop_iframe1", p1_health, 13);
    ticks(1);  cyc(0, 0, 1, 0); chk("p1_third_hit", p1_health, 11);

    // P2 blocked hits then guard break (last one coincides with a tick)
    p2_blocking = 1;
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 1);
      chk("p2_block_shield", p2_shield, 12 - 3 * k);
      chk("p2_block_health", p2_health, 15);
      ticks(30);
    end
    cyc(0, 1, 0, 1);
    chk("p2_guard_shield", p2_shield, 0);
    chk("p2_guard_health", p2_health, 13);
    p2_blocking = 0;

    // P1 regeneration
    p1_blocking = 1;
    cyc(0, 0, 1, 0);
    chk("p1_block_shield", p1_shield, 12);
    chk("p1_block_health", p1_health, 11);
    p1_blocking = 0;
    ticks(59); chk("p1_regen_59", p1_shield, 12);
    ticks(1);  chk("p1_regen_60", p1_shield, 13);
    ticks(58);
    p1_blocking = 1; ticks(1); p1_blocking = 0;
    chk("p1_regen_blocked", p1_shield, 13);
    ticks(59); chk("p1_regen_cleared", p1_shield, 13);
    ticks(1);  chk("p1_regen_resumed", p1_shield, 14);

    // P2 knockout; first hit lands with a tick so iframe must be a full 30
    cyc(0, 1, 0, 1); chk("p2_hit_with_tick", p2_health, 11);
    ticks(29); cyc(0, 0, 0, 1); chk("p2_drop_after29", p2_health, 11);
    ticks(1);  cyc(0, 0, 0, 1); chk("p2_hit_after30", p2_health, 9);
    for (int k = 0; k < 4; k++) begin
      ticks(30); cyc(0, 0, 0, 1);
      chk("p2_descend", p2_health, 7 - 2 * k);
    end
    ticks(30); cyc(0, 0, 0, 1);
    chk("p2_ko_health", p2_health, 0);
    chk("p2_ko_bits", ko, 2);
    chk("p2_ko_fighting", fighting, 0);
    cyc(0, 1, 1, 1); ticks(3);
    chk("ko_hold_p1", p1_health, 11);
    chk("ko_hold_ko", ko, 2);

    cyc(1, 1, 1, 1);
    chk("restart_p1_health", p1_health, 15);
    chk("restart_p2_health", p2_health, 15);
    chk("restart_p1_shield", p1_shield, 15);
    chk("restart_ko", ko, 0);
    chk("restart_fighting", fighting, 1);

    // simultaneous KO
    for (int k = 0; k < 7; k++) begin
      cyc(0, 0, 1, 1); ticks(30);
    end
    chk("draw_pre_p1", p1_health, 1);
    cyc(0, 0, 1, 1);
    chk("draw_ko", ko, 3);
    chk("draw_p1_health", p1_health, 0);
    chk("draw_fighting", fighting, 0);

    // asynchronous reset mid-round with iframe running
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0); chk("mid_hit", p1_health, 13);
    ticks(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_health", p1_health, 15);
    chk("async_rst_shield", p1_shield, 15);
    chk("async_rst_fighting", fighting, 0);
    chk("async_rst_ko", ko, 0);
    @(negedge clk) rst_n = 1'b1;
    cyc(0, 1, 1, 1);
    chk("post_rst_idle_health", p1_health, 15);
    chk("post_rst_idle_fighting", fighting, 0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
